// File: rtl/systolic_input_feeder.sv
// Input feeder for a 3x3 systolic array: buffers one batch of 3-element vectors,
// then streams them with the diagonal skew (row i delayed i cycles) plus start/done control.
module systolic_input_feeder #(
  parameter int DATA_W       = 16,
  parameter int FIFO_DEPTH   = 8,
  parameter int DRAIN_CYCLES = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data_0,
  input  logic [DATA_W-1:0] in_data_1,
  input  logic [DATA_W-1:0] in_data_2,
  input  logic              in_last,
  output logic [DATA_W-1:0] feed_0,
  output logic [DATA_W-1:0] feed_1,
  output logic [DATA_W-1:0] feed_2,
  output logic [2:0]        feed_valid,
  output logic              sa_start,
  output logic              busy,
  output logic              done
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CW-1:0] FULL_CNT   = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] ONE_CNT    = CW'(1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);
  localparam logic [DATA_W-1:0] ZERO_D = {DATA_W{1'b0}};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_STREAM = 2'd2,
    S_DRAIN  = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [3*DATA_W-1:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [DW-1:0]         drain_q, drain_d;
  logic                  done_q, done_d;
  logic                  start_q, start_d;
  logic                  in_ready_s, accept_s, pop_s, last_accept_s;
  logic [3*DATA_W-1:0]   head_s;

  // Skew pipeline: lane 0 has one stage, lane 1 two, lane 2 three
  logic [DATA_W-1:0]     l0_q, l1a_q, l1b_q, l2a_q, l2b_q, l2c_q;
  logic                  v0_q, v1a_q, v1b_q, v2a_q, v2b_q, v2c_q;

  assign accept_s      = in_valid & in_ready_s;
  assign last_accept_s = in_last | ((count_q + ONE_CNT) == FULL_CNT);
  assign head_s        = mem_q[rd_ptr_q];

  // Next-state, FIFO bookkeeping and handshake decode
  always_comb begin
    state_d    = state_q;
    drain_d    = drain_q;
    done_d     = 1'b0;
    in_ready_s = 1'b0;
    pop_s      = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready_s = rst;
        if (accept_s) begin
          state_d = last_accept_s ? S_STREAM : S_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        in_ready_s = rst & (count_q < FULL_CNT);
        if (accept_s && last_accept_s) begin
          state_d = S_STREAM;
        end else begin
          state_d = S_LOAD;
        end
      end
      S_STREAM: begin
        pop_s = 1'b1;
        if (count_q == ONE_CNT) begin
          state_d = S_DRAIN;
          drain_d = {DW{1'b0}};
        end else begin
          state_d = S_STREAM;
        end
      end
      S_DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          drain_d = drain_q + DW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    wr_ptr_d = accept_s ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
    rd_ptr_d = pop_s ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
    case ({accept_s, pop_s})
      2'b10:   count_d = count_q + ONE_CNT;
      2'b01:   count_d = count_q - ONE_CNT;
      default: count_d = count_q;
    endcase
    start_d = (state_d == S_STREAM) || (state_d == S_DRAIN);
  end

  // Control state and FIFO pointers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
      drain_q  <= {DW{1'b0}};
      done_q   <= 1'b0;
      start_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      drain_q  <= drain_d;
      done_q   <= done_d;
      start_q  <= start_d;
    end
  end

  // Vector storage; contents are don't-care while the count says empty
  always_ff @(posedge clk) begin
    if (accept_s) begin
      mem_q[wr_ptr_q] <= {in_data_2, in_data_1, in_data_0};
    end
  end

  // Skew registers; empty slots carry zeros so the array accumulates nothing
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      l0_q  <= ZERO_D;  v0_q  <= 1'b0;
      l1a_q <= ZERO_D;  v1a_q <= 1'b0;
      l1b_q <= ZERO_D;  v1b_q <= 1'b0;
      l2a_q <= ZERO_D;  v2a_q <= 1'b0;
      l2b_q <= ZERO_D;  v2b_q <= 1'b0;
      l2c_q <= ZERO_D;  v2c_q <= 1'b0;
    end else begin
      l0_q  <= pop_s ? head_s[DATA_W-1:0] : ZERO_D;
      v0_q  <= pop_s;
      l1a_q <= pop_s ? head_s[2*DATA_W-1:DATA_W] : ZERO_D;
      v1a_q <= pop_s;
      l1b_q <= l1a_q;
      v1b_q <= v1a_q;
      l2a_q <= pop_s ? head_s[3*DATA_W-1:2*DATA_W] : ZERO_D;
      v2a_q <= pop_s;
      l2b_q <= l2a_q;
      v2b_q <= v2a_q;
      l2c_q <= l2b_q;
      v2c_q <= v2b_q;
    end
  end

  assign in_ready   = in_ready_s;
  assign feed_0     = l0_q;
  assign feed_1     = l1b_q;
  assign feed_2     = l2c_q;
  assign feed_valid = {v2c_q, v1b_q, v0_q};
  assign sa_start   = start_q;
  assign busy       = start_q;
  assign done       = done_q;

endmodule

// File: tb/tb_systolic_input_feeder.sv
// Scoreboard bench for systolic_input_feeder: expected lane elements (value + cycle)
// are queued when a batch is accepted and checked as the skewed outputs appear.
module tb_systolic_input_feeder;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data_0 = '0;
  logic [DW-1:0] in_data_1 = '0;
  logic [DW-1:0] in_data_2 = '0;
  logic          in_last = 1'b0;
  logic [DW-1:0] feed_0, feed_1, feed_2;
  logic [2:0]    feed_valid;
  logic          sa_start, busy, done;

  systolic_input_feeder #(.DATA_W(DW), .FIFO_DEPTH(8), .DRAIN_CYCLES(5)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data_0(in_data_0), .in_data_1(in_data_1), .in_data_2(in_data_2),
    .in_last(in_last),
    .feed_0(feed_0), .feed_1(feed_1), .feed_2(feed_2),
    .feed_valid(feed_valid), .sa_start(sa_start), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d;
    int            c;
  } exp_t;

  exp_t lane_q [3][$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   done_seen = 0;
  int   acc_cyc = 0;
  int   exp_done = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic monitor();
    logic [DW-1:0] fd [3];
    exp_t          e;
    logic          done_prev;
    done_prev = 1'b0;
    forever begin
      @(negedge clk);
      fd[0] = feed_0;
      fd[1] = feed_1;
      fd[2] = feed_2;
      if (rst) begin
        for (int i = 0; i < 3; i++) begin
          n_checks++;
          if (feed_valid[i]) begin
            if (lane_q[i].size() == 0) begin
              n_fail++;
              $display("FAIL lane%0d_unexpected: valid with %0d at cycle %0d, required no valid element", i, fd[i], cyc);
            end else begin
              e = lane_q[i].pop_front();
              if (fd[i] !== e.d || cyc != e.c) begin
                n_fail++;
                $display("FAIL lane%0d_data: got %0d at cycle %0d, required %0d at cycle %0d", i, fd[i], cyc, e.d, e.c);
              end
            end
          end else if (fd[i] !== '0) begin
            n_fail++;
            $display("FAIL lane%0d_idle_zero: got %0d at cycle %0d, required 0", i, fd[i], cyc);
          end
        end
        if (done) begin
          done_seen++;
          n_checks++;
          if (done_prev) begin
            n_fail++;
            $display("FAIL done_width: done high again at cycle %0d, required single-cycle pulse", cyc);
          end
        end
        done_prev = done;
      end else begin
        done_prev = 1'b0;
      end
    end
  endtask

  task automatic push_vec(input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic [DW-1:0] c, input logic last);
    int guard;
    guard = 0;
    in_valid = 1'b1; in_data_0 = a; in_data_1 = b; in_data_2 = c; in_last = last;
    while (!in_ready && guard < 64) begin
      @(negedge clk);
      guard++;
    end
    n_checks++;
    if (!in_ready) begin
      n_fail++;
      $display("FAIL push_ready: in_ready=%0b at cycle %0d, required 1 within 64 cycles", in_ready, cyc);
    end
    @(posedge clk);
    #1;
    acc_cyc   = cyc;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_data_0 = DW'($urandom);
    in_data_1 = DW'($urandom);
    in_data_2 = DW'($urandom);
  endtask

  task automatic run_batch(input int k, input int base, input bit use_last,
                           input bit at_done, output int t0);
    exp_t e;
    for (int j = 0; j < k; j++) begin
      if (!(j == 0 && at_done)) @(negedge clk);
      push_vec(DW'(base + 3*j), DW'(base + 3*j + 1), DW'(base + 3*j + 2), use_last && (j == k - 1));
    end
    t0 = acc_cyc;
    for (int j = 0; j < k; j++) begin
      for (int i = 0; i < 3; i++) begin
        e.d = DW'(base + 3*j + i);
        e.c = t0 + 1 + j + i;
        lane_q[i].push_back(e);
      end
    end
    exp_done = t0 + k + 5;
  endtask

  task automatic wait_done(input string tag);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!done && guard < 64) begin
      @(negedge clk);
      guard++;
    end
    n_checks++;
    if (!done || cyc != exp_done) begin
      n_fail++;
      $display("FAIL %s_done: done=%0b at cycle %0d, required 1 at cycle %0d", tag, done, cyc, exp_done);
    end
    n_checks++;
    if (lane_q[0].size() + lane_q[1].size() + lane_q[2].size() != 0) begin
      n_fail++;
      $display("FAIL %s_drained: %0d elements still expected at done, required 0", tag,
               lane_q[0].size() + lane_q[1].size() + lane_q[2].size());
    end
  endtask

  task automatic test_reset();
    logic [3*DW+6:0] outs;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    outs = {feed_0, feed_1, feed_2, feed_valid, sa_start, busy, done, in_ready};
    n_checks++;
    if (outs !== '0) begin
      n_fail++;
      $display("FAIL reset_hold: outputs=%h, required all zero", outs);
    end
    rst = 1'b1;
    @(negedge clk);
    outs = {feed_0, feed_1, feed_2, feed_valid, sa_start, busy, done, 1'b0};
    n_checks++;
    if (outs !== '0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release: outputs=%h in_ready=%0b, required zero and in_ready=1", outs, in_ready);
    end
  endtask

  task automatic test_single();
    int t0;
    run_batch(1, 1, 1'b1, 1'b0, t0);
    wait_done("single");
  endtask

  task automatic test_k3();
    int   t0;
    logic exp_on;
    run_batch(3, 1, 1'b1, 1'b0, t0);
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      exp_on = (cyc >= t0) && (cyc <= t0 + 7);
      n_checks++;
      if (sa_start !== exp_on || busy !== exp_on) begin
        n_fail++;
        $display("FAIL k3_start: sa_start=%0b busy=%0b at cycle t0+%0d, required %0b", sa_start, busy, cyc - t0, exp_on);
      end
      n_checks++;
      if (done !== (cyc == t0 + 8)) begin
        n_fail++;
        $display("FAIL k3_done: done=%0b at cycle t0+%0d, required %0b", done, cyc - t0, (cyc == t0 + 8));
      end
      if (cyc == t0 + 3) begin
        n_checks++;
        if (feed_0 !== 16'd7 || feed_1 !== 16'd5 || feed_2 !== 16'd3 || feed_valid !== 3'b111) begin
          n_fail++;
          $display("FAIL k3_diag: got %0d/%0d/%0d valid=%b, required 7/5/3 valid=111", feed_0, feed_1, feed_2, feed_valid);
        end
      end
    end
    n_checks++;
    if (lane_q[0].size() + lane_q[1].size() + lane_q[2].size() != 0) begin
      n_fail++;
      $display("FAIL k3_drained: elements outstanding, required 0");
    end
  endtask

  task automatic test_implicit_last();
    int t0;
    for (int b = 0; b < 2; b++) begin
      run_batch(8, 100 + 100*b, 1'b0, 1'b0, t0);
      @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL implicit_ready: in_ready=%0b after 8th accept, required 0", in_ready);
      end
      wait_done("implicit");
    end
  endtask

  task automatic test_back_to_back();
    int t0;
    run_batch(2, 40, 1'b1, 1'b0, t0);
    wait_done("b2b_first");
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_ready: in_ready=%0b in done cycle, required 1", in_ready);
    end
    run_batch(2, 60, 1'b1, 1'b1, t0);
    wait_done("b2b_second");
  endtask

  task automatic test_mid_reset();
    int              t0;
    int              d0;
    logic [3*DW+6:0] outs;
    run_batch(3, 70, 1'b1, 1'b0, t0);
    d0 = done_seen;
    while (cyc < t0 + 2) @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    outs = {feed_0, feed_1, feed_2, feed_valid, sa_start, busy, done, in_ready};
    n_checks++;
    if (outs !== '0) begin
      n_fail++;
      $display("FAIL midreset_async: outputs=%h, required all zero", outs);
    end
    for (int i = 0; i < 3; i++) lane_q[i].delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_idle: in_ready=%0b busy=%0b, required 1/0", in_ready, busy);
    end
    repeat (12) @(negedge clk);
    n_checks++;
    if (done_seen != d0) begin
      n_fail++;
      $display("FAIL midreset_nodone: %0d done pulses after reset, required 0", done_seen - d0);
    end
    run_batch(1, 90, 1'b1, 1'b0, t0);
    wait_done("post_reset");
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_single();
    test_k3();
    test_implicit_last();
    test_back_to_back();
    test_mid_reset();
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/systolic_input_feeder.md
Name: systolic_input_feeder

Overview:
- Upstream stage of the 3x3 systolic array: buffers a batch of 3-element activation vectors, then drives the array's three row inputs with the diagonal skew it needs (row i delayed i cycles).
- Generates the array's start qualifier and a one-cycle done pulse once the last skewed element plus array pipeline have drained.
- Pure data movement; no arithmetic on payload.

Parameters:
- DATA_W, 16, width of each activation element (matches array PE data width).
- FIFO_DEPTH, 8, max vectors per batch (power of 2, >=2).
- DRAIN_CYCLES, 5, cycles held in DRAIN after last pop (2 skew + 3 array rows).

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  asynchronous active-low reset (0 = reset asserted).
- in_valid  input  1  upstream vector valid.
- in_ready  output  1  feeder can accept a vector this cycle.
- in_data_0 / in_data_1 / in_data_2  input  DATA_W each  vector elements for array rows 1/2/3.
- in_last  input  1  qualifies final vector of batch.
- feed_0 / feed_1 / feed_2  output  DATA_W each  skewed data to array row inputs 1/2/3.
- feed_valid  output  3  per-lane valid, bit i for feed_i.
- sa_start  output  1  array start qualifier, high during STREAM and DRAIN.
- busy  output  1  high in any state but IDLE/LOAD.
- done  output  1  one-cycle pulse at batch completion.

Behaviour:
- Reset (rst=0, async): state IDLE, FIFO empty, all skew registers 0; feed_* = 0, feed_valid = 0, sa_start = 0, busy = 0, done = 0, in_ready = 0 while asserted. Reset mid-batch discards all buffered vectors; no done pulse.
- States: IDLE, LOAD, STREAM, DRAIN.
- IDLE: in_ready = 1. Accept (in_valid & in_ready) writes vector, goes to LOAD; if that vector has in_last or FIFO_DEPTH==1, go directly to STREAM.
- LOAD: in_ready = 1 while count < FIFO_DEPTH. Each accept writes vector. Accept with in_last = 1, or accept that makes count == FIFO_DEPTH (implicit last), moves to STREAM next cycle.
- STREAM/DRAIN: in_ready = 0; in_valid ignored.
- Batch size K = vectors accepted, 1..FIFO_DEPTH.
- STREAM: pops one vector per cycle for K cycles, then DRAIN. Let t0 = first STREAM cycle. Vector k element i appears on feed_i with feed_valid[i] = 1 in cycle t0+1+k+i (lane 0 one register, lane 1 two, lane 2 three).
- Idle lanes: when no valid element is present, feed_i = 0 and feed_valid[i] = 0. Zeros are required so array PEs accumulate nothing.
- sa_start: 1 from t0 through the last DRAIN cycle; busy identical.
- DRAIN: counts DRAIN_CYCLES cycles starting the cycle after the last pop, then goes to IDLE.
- done: 1 in the first IDLE cycle after DRAIN, exactly one cycle. in_ready is also 1 in that cycle; a same-cycle accept is legal and starts the next batch.
- FIFO: circular, pointer wrap modulo FIFO_DEPTH, count width clog2(FIFO_DEPTH)+1. Never written when full; never read when empty (FSM guarantees both).
- Latency: last element (vector K-1, lane 2) at t0+K+2. done at t0+K+DRAIN_CYCLES.
- in_data_* sampled only on accept; changes while in_ready=0 have no effect.

Test Plan:
- Reset: hold rst=0 for 3 cycles, then release -> all outputs 0 and in_ready=1 in the first cycle after release; no done.
- Single vector (1,2,3) with in_last -> feed_0=1 at t0+1, feed_1=2 at t0+2, feed_2=3 at t0+3; feed_valid=001, 010, 100 in those cycles, 000 otherwise; done at t0+6.
- K=3 vectors (1,2,3), (4,5,6), (7,8,9) -> at t0+3: feed_0=7, feed_1=5, feed_2=3, feed_valid=111; sa_start high t0..t0+7; done at t0+8.
- Implicit last: 8 vectors, no in_last -> in_ready drops after 8th accept; STREAM of 8 pops; element order preserved across pointer wrap on the second batch.
- Back-to-back: assert in_valid with in_last during the done cycle -> vector accepted, second batch streams correctly, no lost or duplicated vector.
- Mid-stream reset: pull rst=0 at t0+2 of a K=3 batch -> outputs 0 immediately (async); FIFO empty after release; no done pulse.
